// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shift-register frame block: direction codes,
// sequencer state encoding and the constant clog2 used to size counters.
package shiftreg_pkg;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/shiftreg_core.sv
// WIDTH-bit parallel-load / serial-shift datapath; direction chosen per cycle
// by the controlling sequencer.
module shiftreg_core
   import shiftreg_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             clr,
   input  logic             ld,
   input  logic             shift,
   input  logic             dir,
   input  logic [WIDTH-1:0] Din,
   input  logic             SI,
   output logic [WIDTH-1:0] Dout,
   output logic             shiftout
);

   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (ld) begin
         data_d = Din;
      end else if (shift) begin
         if (dir == DIR_LSB_FIRST) begin
            data_d = {SI, data_q[WIDTH-1:1]};
         end else begin
            data_d = {data_q[WIDTH-2:0], SI};
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (clr) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign Dout     = data_q;
   assign shiftout = (dir == DIR_LSB_FIRST) ? data_q[0] : data_q[WIDTH-1];

endmodule

// File: rtl/shiftreg_frame.sv
// Shift register with manual ld/shift control and a frame sequencer that
// shifts a programmed number of bits on external tick strobes.
module shiftreg_frame
   import shiftreg_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             clr,
   input  logic             ld,
   input  logic             shift,
   input  logic             start,
   input  logic             tick,
   input  logic [CNT_W-1:0] len,
   input  logic             lsb_first,
   input  logic [WIDTH-1:0] Din,
   input  logic             SI,
   output logic [WIDTH-1:0] Dout,
   output logic             shiftout,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bitcnt
);

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] eff_len;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic             core_ld, core_shift, core_dir;

   assign eff_len = (len == '0 || len > WIDTH_C) ? WIDTH_C : len;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      done_d     = 1'b0;
      core_ld    = 1'b0;
      core_shift = 1'b0;
      core_dir   = lsb_first;
      case (state_q)
         IDLE: begin
            // ld alongside start loads Din so the frame shifts the fresh word
            if (start) begin
               rem_d   = eff_len;
               dir_d   = lsb_first;
               cnt_d   = '0;
               state_d = RUN;
               core_ld = ld;
            end else if (ld) begin
               core_ld = 1'b1;
            end else if (shift) begin
               core_shift = 1'b1;
            end
         end
         RUN: begin
            core_dir = dir_q;
            if (tick) begin
               core_shift = 1'b1;
               cnt_d      = cnt_q + ONE_C;
               rem_d      = rem_q - ONE_C;
               if (rem_q == ONE_C) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (clr) begin
         state_q <= IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= DIR_MSB_FIRST;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   shiftreg_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .CLK      (CLK),
      .clr      (clr),
      .ld       (core_ld),
      .shift    (core_shift),
      .dir      (core_dir),
      .Din      (Din),
      .SI       (SI),
      .Dout     (Dout),
      .shiftout (shiftout)
   );

   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign bitcnt = cnt_q;

endmodule

// File: doc/shiftreg_frame.md
# shiftreg_frame

Parametrised successor to the diagnostic serial shift register. Provides a WIDTH-bit parallel-load / serial-shift register with selectable shift direction and a built-in frame sequencer: one `start` shifts a programmed number of bits on external `tick` strobes and reports `busy`/`done`. Sits in the AFC diagnostics Wishbone path between register-bank logic and serial diagnostic links; manual `ld`/`shift` operation is kept for existing users.

## Interface
- WIDTH, 8: register width in bits; legal range 2..64.
- CNT_W, clog2(WIDTH+1): width of the length and bit-count fields; derived, never overridden.

- CLK  in  1  clock; all logic is on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- ld  in  1  load `Din`; honoured only in IDLE.
- shift  in  1  manual one-bit shift; honoured only in IDLE.
- start  in  1  begin an automatic frame; honoured only in IDLE.
- tick  in  1  shift strobe; used only in RUN.
- len  in  CNT_W  frame length in bits, sampled on `start`; 0 or >WIDTH means WIDTH.
- lsb_first  in  1  direction: 0 = MSB-first, 1 = LSB-first; sampled on `start`, used live in IDLE.
- Din  in  WIDTH  parallel load data.
- SI  in  1  serial input bit.
- Dout  out  WIDTH  register contents.
- shiftout  out  1  serial output bit.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at frame completion.
- bitcnt  out  CNT_W  bits shifted in the current or last frame.

## Operation
- States: IDLE, RUN. Reset state is IDLE.
- Shift op: MSB-first gives Dout <= {Dout[WIDTH-2:0], SI}; LSB-first gives Dout <= {SI, Dout[WIDTH-1:1]}.
- shiftout is combinational:
  - MSB-first: Dout[WIDTH-1].
  - LSB-first: Dout[0].
  - Direction source: the latched value in RUN, live `lsb_first` in IDLE.
- IDLE priority: clr > start > ld > shift.
  - start: latch effective length into `remaining`, latch direction, clear bitcnt, go to RUN.
  - start with ld both high: Din is also loaded in the same cycle, so the frame shifts freshly loaded data.
  - start without ld: Dout is unchanged.
  - ld alone: Dout <= Din.
  - shift alone: one shift op in the live direction; bitcnt unchanged.
- RUN: ld, shift and start are ignored. Each cycle with tick=1:
  - perform one shift op;
  - bitcnt += 1 and remaining -= 1;
  - if remaining was 1, go to IDLE and assert done.
- A tick coincident with start is ignored, because the block is still in IDLE that cycle.
- clr in any state, including mid-frame:
  - Dout, bitcnt, remaining and latched direction are cleared;
  - state goes to IDLE, busy=0;
  - no done is issued.
- A start asserted in the cycle after done is accepted (back-to-back frames).

## Timing
- Reset values: Dout=0, busy=0, done=0, bitcnt=0, shiftout=0.
- ld/shift: Dout updates on the edge where the input is sampled, so it is visible the next cycle.
- start at edge k: busy=1 from cycle k+1.
- Last tick at edge m:
  - Dout holds the final word from cycle m+1;
  - busy=0 and done=1 in cycle m+1 only;
  - bitcnt equals the frame length from cycle m+1 and holds until the next start or clr.
- Frame duration is exactly len ticks, with any gap between ticks; throughput is up to 1 bit per clock when tick is held high.

## Structure
- Shared package shiftreg_pkg holds:
  - DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1;
  - the state encoding IDLE=0, RUN=1;
  - a constant clog2 function used to derive CNT_W.
- Natural sub-module: shiftreg_core.
  - Contains the WIDTH-bit datapath only: clr/ld/shift/dir/SI in, Dout and shiftout out.
  - The frame FSM and counters in shiftreg_frame drive it.

## Test plan
- Reset/manual: WIDTH=8. Pulse clr, then ld with Din=0xA5, then 3 manual MSB-first shifts with SI=1 → Dout=0x2F, shiftout=0; busy and done stay 0.
- LSB-first frame: ld+start with Din=0x81, len=8, lsb_first=1, SI=0, tick held high → shiftout sequence 1,0,0,0,0,0,0,1. Then done pulses 1 cycle, Dout=0x00, bitcnt=8.
- Partial frame with sparse ticks: Din=0xF0, len=3, MSB-first, SI=1, tick every 4th cycle → done 1 cycle after the 3rd tick, Dout=0x87, bitcnt=3. ld and shift pulses issued during RUN have no effect.
- len=0 and len=15 at WIDTH=8 → both frames take exactly 8 ticks; bitcnt=8.
- clr mid-frame: after 4 of 8 ticks assert clr → next cycle Dout=0, busy=0, bitcnt=0; no done pulse ever appears.
- Back-to-back and coincidence: tick asserted in the start cycle is not counted. start in the cycle after done is accepted. WIDTH=32 frame with len=32 → done after exactly 32 ticks.
